fixed_mac_rr_sched: RTL and testbench

- Round-robin scheduler that shares one fixed_mac instance among N_REQ vector requesters.
- Grants one requester for a whole dot-product vector and splits each operand pair into the MAC's separate A and B handshakes.
- Waits for the MAC result and returns it on a common result channel tagged with the requester id.
- Sits between the requester streams and the fixed_mac A/B/out channels.

---
 rtl/fixed_mac_rr_sched.sv | 190 +++++++++++++++++++
 tb/tb_fixed_mac_rr_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_mac_rr_sched.sv
// Round-robin scheduler that shares one fixed_mac among N_REQ vector requesters.
// Optional statistics counters are enabled with FIXED_MAC_RR_SCHED_STATS_EN.
module fixed_mac_rr_sched #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int WA      = 12,
  parameter int WB      = 8,
  parameter int WO      = 45,
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ*WA-1:0] req_a_data,
  input  logic [N_REQ*WB-1:0] req_b_data,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [WA-1:0]      mac_a_data,
  output logic               mac_a_valid,
  input  logic               mac_a_ready,
  output logic               mac_a_last,
  output logic [WB-1:0]      mac_b_data,
  output logic               mac_b_valid,
  input  logic               mac_b_ready,
  output logic               mac_b_last,
  input  logic [WO-1:0]      mac_out_data,
  input  logic               mac_out_valid,
  output logic               mac_out_ready,
  input  logic               mac_overflow,
  input  logic               mac_underflow,
  output logic [WO-1:0]      res_data,
  output logic [ID_W-1:0]    res_id,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_ovf,
  output logic               res_unf,
  output logic               len_err
`ifdef FIXED_MAC_RR_SCHED_STATS_EN
  ,
  output logic [N_REQ*16-1:0] vec_cnt,
  output logic [31:0]         busy_cycles
`endif
);

  typedef enum logic [2:0] {ARB, LOAD, ISSUE, WAIT_RES, DELIVER} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  gnt_id, rr_ptr, arb_id;
  logic             arb_hit;
  logic [LEN_W-1:0] beat_cnt;
  logic             a_done, b_done, last_q;
  logic             a_fire, b_fire, beat_done, trunc_hit, end_vec, idle_wait, res_fire;

  assign a_fire    = mac_a_valid & mac_a_ready;
  assign b_fire    = mac_b_valid & mac_b_ready;
  assign beat_done = (state == ISSUE) & (a_done | a_fire) & (b_done | b_fire);
  assign trunc_hit = (beat_cnt == LEN_W'(MAX_LEN - 1));
  assign end_vec   = last_q | trunc_hit;
  // Between beats of an open vector: nothing outstanding, waiting on the requester.
  assign idle_wait = (state == ISSUE) & ~mac_a_valid & ~mac_b_valid & ~a_done & ~b_done;
  assign res_fire  = res_valid & res_ready;

  assign req_ready     = (state == LOAD) ? (N_REQ'(1) << gnt_id) : '0;
  assign mac_out_ready = (state == WAIT_RES);
  assign res_valid     = (state == DELIVER);

  // Descending scan so the nearest requester after rr_ptr is the one that sticks.
  always_comb begin
    int idx;
    idx     = 0;
    arb_hit = 1'b0;
    arb_id  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        arb_hit = 1'b1;
        arb_id  = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:      if (arb_hit) state_nxt = LOAD;
      LOAD:     state_nxt = ISSUE;
      ISSUE: begin
        if (beat_done) begin
          if (end_vec)                state_nxt = WAIT_RES;
          else if (req_valid[gnt_id]) state_nxt = LOAD;
        end else if (idle_wait && req_valid[gnt_id]) begin
          state_nxt = LOAD;
        end
      end
      WAIT_RES: if (mac_out_valid) state_nxt = DELIVER;
      DELIVER:  if (res_ready)     state_nxt = ARB;
      default:  state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_id      <= '0;
      rr_ptr      <= ID_W'(N_REQ - 1);
      beat_cnt    <= '0;
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      last_q      <= 1'b0;
      mac_a_data  <= '0;
      mac_a_valid <= 1'b0;
      mac_a_last  <= 1'b0;
      mac_b_data  <= '0;
      mac_b_valid <= 1'b0;
      mac_b_last  <= 1'b0;
      res_data    <= '0;
      res_id      <= '0;
      res_ovf     <= 1'b0;
      res_unf     <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        ARB: if (arb_hit) begin
          gnt_id <= arb_id;
          rr_ptr <= arb_id;
        end
        LOAD: begin
          mac_a_data  <= req_a_data[int'(gnt_id)*WA +: WA];
          mac_b_data  <= req_b_data[int'(gnt_id)*WB +: WB];
          last_q      <= req_last[gnt_id];
          mac_a_valid <= 1'b1;
          mac_b_valid <= 1'b1;
          mac_a_last  <= req_last[gnt_id] | trunc_hit;
          mac_b_last  <= req_last[gnt_id] | trunc_hit;
        end
        ISSUE: begin
          if (a_fire) begin
            mac_a_valid <= 1'b0;
            mac_a_last  <= 1'b0;
            a_done      <= 1'b1;
          end
          if (b_fire) begin
            mac_b_valid <= 1'b0;
            mac_b_last  <= 1'b0;
            b_done      <= 1'b1;
          end
          if (beat_done) begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            if (end_vec) begin
              beat_cnt <= '0;
              len_err  <= trunc_hit & ~last_q;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        WAIT_RES: if (mac_out_valid) begin
          res_data <= mac_out_data;
          res_ovf  <= mac_overflow;
          res_unf  <= mac_underflow;
          res_id   <= gnt_id;
        end
        default: ;
      endcase
    end
  end

`ifdef FIXED_MAC_RR_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec_cnt     <= '0;
      busy_cycles <= '0;
    end else begin
      if (state != ARB) busy_cycles <= busy_cycles + 32'd1;
      for (int i = 0; i < N_REQ; i++) begin
        if (res_fire && res_id == ID_W'(i) && vec_cnt[i*16 +: 16] != 16'hFFFF)
          vec_cnt[i*16 +: 16] <= vec_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fixed_mac_rr_sched.sv
// Directed bench for fixed_mac_rr_sched: the bench plays requesters, MAC and result sink.
module tb_fixed_mac_rr_sched;
  localparam int N_REQ = 4, ID_W = 2, WA = 12, WB = 8, WO = 45, MAX_LEN = 256, LEN_W = 9;

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  logic [N_REQ*WA-1:0] req_a_data = '0;
  logic [N_REQ*WB-1:0] req_b_data = '0;
  logic [N_REQ-1:0]    req_valid = '0, req_last = '0, req_ready;
  logic [WA-1:0]       mac_a_data;
  logic [WB-1:0]       mac_b_data;
  logic                mac_a_valid, mac_a_last, mac_b_valid, mac_b_last;
  logic                mac_a_ready = 1'b0, mac_b_ready = 1'b0;
  logic [WO-1:0]       mac_out_data = '0;
  logic                mac_out_valid = 1'b0, mac_out_ready;
  logic                mac_overflow = 1'b0, mac_underflow = 1'b0;
  logic [WO-1:0]       res_data;
  logic [ID_W-1:0]     res_id;
  logic                res_valid, res_ready = 1'b0, res_ovf, res_unf, len_err;
`ifdef FIXED_MAC_RR_SCHED_STATS_EN
  logic [N_REQ*16-1:0] vec_cnt;
  logic [31:0]         busy_cycles;
`endif

  fixed_mac_rr_sched #(.N_REQ(N_REQ), .ID_W(ID_W), .WA(WA), .WB(WB), .WO(WO),
                       .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .req_a_data(req_a_data), .req_b_data(req_b_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready),
    .mac_a_data(mac_a_data), .mac_a_valid(mac_a_valid), .mac_a_ready(mac_a_ready), .mac_a_last(mac_a_last),
    .mac_b_data(mac_b_data), .mac_b_valid(mac_b_valid), .mac_b_ready(mac_b_ready), .mac_b_last(mac_b_last),
    .mac_out_data(mac_out_data), .mac_out_valid(mac_out_valid), .mac_out_ready(mac_out_ready),
    .mac_overflow(mac_overflow), .mac_underflow(mac_underflow),
    .res_data(res_data), .res_id(res_id), .res_valid(res_valid), .res_ready(res_ready),
    .res_ovf(res_ovf), .res_unf(res_unf), .len_err(len_err)
`ifdef FIXED_MAC_RR_SCHED_STATS_EN
    , .vec_cnt(vec_cnt), .busy_cycles(busy_cycles)
`endif
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Values sampled on the falling edge of the most recent cycle()
  logic [N_REQ-1:0] s_rr;
  logic             s_afire, s_bfire, s_alast, s_blast, s_lerr, s_resfire;
  logic [WA-1:0]    s_adata;
  logic [WB-1:0]    s_bdata;
  logic [ID_W-1:0]  s_res_id;

  task automatic cycle();
    @(negedge clk);
    s_rr      = req_ready;
    s_afire   = mac_a_valid & mac_a_ready;
    s_bfire   = mac_b_valid & mac_b_ready;
    s_alast   = mac_a_last;
    s_blast   = mac_b_last;
    s_adata   = mac_a_data;
    s_bdata   = mac_b_data;
    s_lerr    = len_err;
    s_resfire = res_valid & res_ready;
    s_res_id  = res_id;
    chk("req_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int r, input bit v, input logic [WA-1:0] a,
                         input logic [WB-1:0] b, input bit l);
    req_valid[r]          = v;
    req_last[r]           = l;
    req_a_data[r*WA +: WA] = a;
    req_b_data[r*WB +: WB] = b;
  endtask

  int alast_q[$], blast_q[$], res_ids[$];
  int lerr_cnt, res_beat, a_beats, b_beats;

  // Streams n pairs from requester r; A is a0 (+pair index when ainc).
  task automatic stream(input int r, input int n, input bit has_last,
                        input logic [WA-1:0] a0, input bit ainc, input logic [WB-1:0] b0);
    int p, cyc;
    logic [WA-1:0] ea;
    p = 0; cyc = 0; a_beats = 0; b_beats = 0; lerr_cnt = 0; res_beat = -1;
    alast_q.delete(); blast_q.delete(); res_ids.delete();
    set_req(r, 1'b1, a0, b0, has_last && n == 1);
    while (!(p == n && a_beats == n && b_beats == n) && cyc < 4000) begin
      cycle(); cyc++;
      if (s_rr[r]) p++;
      if (s_afire) begin
        a_beats++;
        ea = ainc ? WA'(int'(a0) + a_beats - 1) : a0;
        chk("a_data", s_adata, ea);
        if (s_alast) alast_q.push_back(a_beats);
      end
      if (s_bfire) begin
        b_beats++;
        chk("b_data", s_bdata, b0);
        if (s_blast) blast_q.push_back(b_beats);
      end
      if (s_lerr) lerr_cnt++;
      if (s_resfire) begin
        res_beat = a_beats;
        res_ids.push_back(int'(s_res_id));
      end
      set_req(r, p < n, ainc ? WA'(int'(a0) + p) : a0, b0, has_last && p == n - 1);
    end
    chk("stream_in_budget", 64'(cyc < 4000), 64'd1);
  endtask

  // Waits for a result; with hold>0 res_ready stays low that many cycles first.
  task automatic wait_res(input logic [ID_W-1:0] id, input logic [WO-1:0] d,
                          input bit ovf, input bit unf, input int hold);
    int cyc;
    cyc = 0;
    res_ready = (hold == 0);
    while (!res_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("res_arrive", res_valid, 1);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_data", res_data, d);
      chk("hold_res_id", res_id, id);
      chk("hold_res_ovf", res_ovf, ovf);
      chk("hold_mac_out_ready", mac_out_ready, 0);
      chk("hold_no_grant", req_ready, 0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("res_data", res_data, d);
    chk("res_id", res_id, id);
    chk("res_ovf", res_ovf, ovf);
    chk("res_unf", res_unf, unf);
    @(posedge clk); #1;
    chk("res_valid_drop", res_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ord[5];
    int g, rc, cyc, loads;
    ord = '{0, 1, 2, 3, 0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mac_a_valid", mac_a_valid, 0);
    chk("rst_mac_b_valid", mac_b_valid, 0);
    chk("rst_mac_a_last", mac_a_last, 0);
    chk("rst_mac_out_ready", mac_out_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_len_err", len_err, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // All four requesters valid, single-pair vectors: grants 0,1,2,3,0
    mac_a_ready = 1; mac_b_ready = 1; mac_out_valid = 1; res_ready = 1;
    mac_out_data = 45'h0_0000_00AA_5500;
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, WA'(12'h010 + i), 8'h05, 1'b1);
    g = 0; rc = 0; cyc = 0;
    while (g < 5 && cyc < 200) begin
      cycle(); cyc++;
      if (s_rr != 0) begin
        chk("grant_order", s_rr, 64'(1) << ord[g]);
        g++;
      end
      if (s_resfire) begin
        chk("res_id_order", s_res_id, ord[rc]);
        rc++;
      end
    end
    chk("grants_seen", g, 5);
    req_valid = '0;
    wait_res(2'd0, 45'h0_0000_00AA_5500, 1'b0, 1'b0, 0);

    // A accepted at cycle n, B at n+3: next LOAD only at n+4
    mac_a_ready = 0; mac_b_ready = 0; req_last = '0;
    set_req(1, 1'b1, 12'h0AB, 8'h11, 1'b0);
    cyc = 0;
    do begin cycle(); cyc++; end while (s_rr != 4'b0010 && cyc < 20);
    chk("split_grant", s_rr, 4'b0010);
    set_req(1, 1'b1, 12'h0AC, 8'h11, 1'b1);
    mac_a_ready = 1;
    cycle();
    chk("split_a_fire_n", s_afire, 1);
    chk("split_a_data", s_adata, 12'h0AB);
    mac_a_ready = 0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("split_a_valid_low", mac_a_valid, 0);
      chk("split_b_valid_high", mac_b_valid, 1);
      chk("split_no_load", req_ready, 0);
      @(posedge clk); #1;
    end
    mac_b_ready = 1;
    @(negedge clk);
    chk("split_b_valid_n3", mac_b_valid, 1);
    chk("split_no_load_n3", req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("split_load_n4", req_ready, 4'b0010);
    chk("split_b_valid_n4", mac_b_valid, 0);
    @(posedge clk); #1;
    req_valid = '0; mac_a_ready = 1;
    mac_out_data = 45'h1F_0000_1234; mac_overflow = 0; mac_underflow = 1;
    wait_res(2'd1, 45'h1F_0000_1234, 1'b0, 1'b1, 0);

    // Req0 three-pair vector, then a 10-cycle stall on res_ready
    res_ready = 0;
    mac_out_data = 45'h0_1234_5678_9; mac_overflow = 1; mac_underflow = 0;
    stream(0, 3, 1'b1, 12'h100, 1'b0, 8'h20);
    chk("v3_a_beats", a_beats, 3);
    chk("v3_b_beats", b_beats, 3);
    chk("v3_a_last_cnt", alast_q.size(), 1);
    chk("v3_a_last_pos", alast_q.size() > 0 ? alast_q[0] : -1, 3);
    chk("v3_b_last_pos", blast_q.size() > 0 ? blast_q[0] : -1, 3);
    set_req(2, 1'b1, 12'h0, 8'h0, 1'b0);
    wait_res(2'd0, 45'h0_1234_5678_9, 1'b1, 1'b0, 10);
    req_valid = '0;

    // Req2: 257 pairs without last, then a closing pair with last
    res_ready = 1;
    mac_out_data = 45'h0_0000_0000_7; mac_overflow = 0; mac_underflow = 1;
    stream(2, 258, 1'b1, 12'h000, 1'b1, 8'h3C);
    chk("trunc_a_beats", a_beats, 258);
    chk("trunc_last_cnt", alast_q.size(), 2);
    chk("trunc_last_pos0", alast_q.size() > 0 ? alast_q[0] : -1, 256);
    chk("trunc_last_pos1", alast_q.size() > 1 ? alast_q[1] : -1, 258);
    chk("trunc_blast_pos0", blast_q.size() > 0 ? blast_q[0] : -1, 256);
    chk("trunc_len_err_cnt", lerr_cnt, 1);
    chk("trunc_res_cnt", res_ids.size(), 1);
    chk("trunc_res_id", res_ids.size() > 0 ? res_ids[0] : -1, 2);
    chk("trunc_res_beat", res_beat, 256);
    wait_res(2'd2, 45'h0_0000_0000_7, 1'b0, 1'b1, 0);

    // Reset in the middle of beat 2 of a req0 vector
    req_last = '0;
    set_req(0, 1'b1, 12'h0EE, 8'h44, 1'b0);
    loads = 0; cyc = 0;
    while (loads < 2 && cyc < 40) begin
      cycle(); cyc++;
      if (s_rr[0]) loads++;
    end
    chk("mid_loads", loads, 2);
    chk("mid_issue_valid", mac_a_valid, 1);
    reset = 1'b0;
    #1;
    chk("arst_mac_a_valid", mac_a_valid, 0);
    chk("arst_mac_b_valid", mac_b_valid, 0);
    chk("arst_mac_a_data", mac_a_data, 0);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_mac_out_ready", mac_out_ready, 0);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_res_data", res_data, 0);
    set_req(0, 1'b1, 12'h0EF, 8'h45, 1'b1);
    set_req(1, 1'b1, 12'h0F0, 8'h46, 1'b1);
    mac_out_data = 45'h0_0000_BEEF; mac_overflow = 0; mac_underflow = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      chk("post_rst_no_res", res_valid, 0);
      s_rr = req_ready;
      @(posedge clk); #1; cyc++;
    end while (s_rr == 0 && cyc < 20);
    chk("post_rst_first_grant", s_rr, 4'b0001);
    req_valid[0] = 1'b0;
    wait_res(2'd0, 45'h0_0000_BEEF, 1'b0, 1'b0, 0);
    wait_res(2'd1, 45'h0_0000_BEEF, 1'b0, 1'b0, 0);
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
